flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Shares one spi_flash_mem word reader between two requesters: port A (instruction fetch) and port B (data or bootloader reads).
- Arbitrates between the ports round-robin and sequences each flash transaction by gating the reader's reset input.
- Returns the 16-bit big-endian word to the granted requester.
- Aborts a transaction with an error flag if the reader never signals ready.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles allowed without mem_ready before the transaction is aborted. Legal range 2..65535.
- CNT_W, 16: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request level; a_addr must be stable while high.
- a_addr  in  24  port A flash byte address.
- a_ack  out  1  one-cycle pulse: port A transaction finished.
- a_err  out  1  valid with a_ack; 1 means timeout abort.
- a_rdata  out  16  port A read word; updated only on a successful ack.
- b_req, b_addr, b_ack, b_err, b_rdata: same as port A, for port B.
- busy  out  1  high while a transaction is in BUSY.
- mem_reset  out  1  drives the spi_flash_mem reset input; high holds the reader idle.
- mem_addr  out  24  drives the reader address; registered.
- mem_rdata  in  16  reader data.
- mem_ready  in  1  reader one-cycle completion pulse.

Behaviour:
- Reset values (asynchronous): state=IDLE, mem_reset=1, mem_addr=0, busy=0, a_ack=b_ack=0, a_err=b_err=0, a_rdata=b_rdata=0, grant=A, last=B (so A wins the first tie), counter=0.
- Acks and errs default to 0 every cycle. They are registered pulses.
- States: IDLE, BUSY, RECOVER.
- IDLE:
  - mem_reset=1.
  - If a_req or b_req is high, select a winner. A single requester wins outright. If both request, the port not equal to last wins.
  - Latch the winner's address into mem_addr and set grant=winner. Set mem_reset<=0, busy<=1, counter<=0; go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - counter increments each cycle.
  - mem_ready=1: copy mem_rdata into the granted port's rdata. Pulse that port's ack with err=0. Set last=grant, mem_reset<=1, busy<=0; go to RECOVER.
  - Otherwise, if counter==TIMEOUT_CYCLES-1: pulse the granted port's ack with err=1 and leave its rdata unchanged. Set last=grant, mem_reset<=1, busy<=0; go to RECOVER.
  - If mem_ready and the timeout land in the same cycle, mem_ready wins and the result is success.
- RECOVER:
  - Exactly one cycle. mem_reset=1 and requests are ignored; go to IDLE.
  - This guarantees the reader sees reset for at least two cycles between transactions.
- Request protocol:
  - The requester drops req no later than the edge after it samples ack.
  - A req still high in IDLE after RECOVER is treated as a new request.
  - If req drops mid-transaction, the transaction still completes and the ack still pulses.
  - Address changes while granted are ignored because mem_addr is latched.
- Latency:
  - Request accepted in IDLE at edge N.
  - Ack appears one cycle after mem_ready is sampled.
  - Minimum spacing between grants is 2 cycles (BUSY exit, then RECOVER).
- Asynchronous reset mid-transaction: everything returns to reset values immediately, and mem_reset=1 aborts the reader. No ack is produced for the interrupted request.
- Only one of a_ack and b_ack can be high in any cycle.

Test Plan:
- Single A read: a_req=1, a_addr=24'h100000, reader model returns 16'hABCD after 104 cycles -> mem_addr=24'h100000, busy for 104 cycles, one a_ack pulse with a_err=0, a_rdata=16'hABCD, b_ack never asserted.
- Simultaneous requests after reset: a_req=b_req=1 held, a_addr=24'h100002, b_addr=24'h180000 -> grant order A, B, A, B. After each ack, mem_addr alternates between those two addresses, and consecutive grants are separated by the RECOVER cycle.
- Timeout: B granted, mem_ready never asserted, TIMEOUT_CYCLES=255 -> b_ack with b_err=1 exactly 255 cycles after grant, b_rdata keeps its prior value, mem_reset high next cycle.
- Ready on the timeout cycle: mem_ready pulses when counter==TIMEOUT_CYCLES-1 with data 16'h1234 -> success ack with err=0, rdata=16'h1234.
- Reset mid-transaction: assert reset 40 cycles into an A transaction -> mem_reset=1, busy=0 with no clock edge needed; no ack; after release, a held a_req is re-granted.
- Requester withdraws: a_req drops 10 cycles after grant -> transaction completes and a_ack still pulses; a later b_req is granted right after RECOVER.

Source files
------------

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one spi_flash_mem word reader between an
// instruction-fetch port (A) and a data/boot port (B), with a ready timeout.
module flash_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [23:0] a_addr,
  output logic        a_ack,
  output logic        a_err,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic [23:0] b_addr,
  output logic        b_ack,
  output logic        b_err,
  output logic [15:0] b_rdata,
  output logic        busy,
  output logic        mem_reset,
  output logic [23:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // Port identifiers: 1'b0 = A, 1'b1 = B.
  state_t            state_r, state_s;
  logic              grant_r, grant_s;
  logic              last_r, last_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              win_s;
  logic              mem_reset_s, busy_s;
  logic [23:0]       mem_addr_s;
  logic              a_ack_s, a_err_s, b_ack_s, b_err_s;
  logic [15:0]       a_rdata_s, b_rdata_s;

  // Winner selection: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    win_s = 1'b0;
    if (a_req && b_req) begin
      win_s = ~last_r;
    end else if (b_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    last_s      = last_r;
    cnt_s       = cnt_r;
    mem_reset_s = mem_reset;
    mem_addr_s  = mem_addr;
    busy_s      = busy;
    a_ack_s     = 1'b0;
    a_err_s     = 1'b0;
    b_ack_s     = 1'b0;
    b_err_s     = 1'b0;
    a_rdata_s   = a_rdata;
    b_rdata_s   = b_rdata;

    case (state_r)
      ST_IDLE: begin
        mem_reset_s = 1'b1;
        if (a_req || b_req) begin
          grant_s     = win_s;
          mem_addr_s  = win_s ? b_addr : a_addr;
          mem_reset_s = 1'b0;
          busy_s      = 1'b1;
          cnt_s       = '0;
          state_s     = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUSY: begin
        cnt_s = cnt_r + CNT_ONE;
        // mem_ready takes priority over a timeout landing on the same cycle.
        if (mem_ready || (cnt_r == CNT_LAST)) begin
          if (grant_r) begin
            b_ack_s = 1'b1;
            b_err_s = ~mem_ready;
            if (mem_ready) begin
              b_rdata_s = mem_rdata;
            end else begin
              b_rdata_s = b_rdata;
            end
          end else begin
            a_ack_s = 1'b1;
            a_err_s = ~mem_ready;
            if (mem_ready) begin
              a_rdata_s = mem_rdata;
            end else begin
              a_rdata_s = a_rdata;
            end
          end
          last_s      = grant_r;
          mem_reset_s = 1'b1;
          busy_s      = 1'b0;
          state_s     = ST_RECOVER;
        end else begin
          state_s = ST_BUSY;
        end
      end

      // One extra reset cycle so the reader sees reset for two cycles minimum.
      ST_RECOVER: begin
        mem_reset_s = 1'b1;
        state_s     = ST_IDLE;
      end

      default: begin
        mem_reset_s = 1'b1;
        busy_s      = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      grant_r   <= 1'b0;
      last_r    <= 1'b1;
      cnt_r     <= '0;
      mem_reset <= 1'b1;
      mem_addr  <= 24'h000000;
      busy      <= 1'b0;
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= 16'h0000;
      b_rdata   <= 16'h0000;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      last_r    <= last_s;
      cnt_r     <= cnt_s;
      mem_reset <= mem_reset_s;
      mem_addr  <= mem_addr_s;
      busy      <= busy_s;
      a_ack     <= a_ack_s;
      a_err     <= a_err_s;
      b_ack     <= b_ack_s;
      b_err     <= b_err_s;
      a_rdata   <= a_rdata_s;
      b_rdata   <= b_rdata_s;
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: transaction-level reference model,
// a simple flash reader model, and directed scenarios with literal expectations.
module tb_flash_arbiter;

  localparam int TO = 255;

  logic        clk;
  logic        reset;
  logic        a_req, b_req;
  logic [23:0] a_addr, b_addr;
  logic        a_ack, a_err, b_ack, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic        busy, mem_reset;
  logic [23:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  flash_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .busy(busy), .mem_reset(mem_reset), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Flash reader model: pulses mem_ready rd_delay cycles after leaving reset (0 = never).
  int          rd_delay = 0;
  logic [15:0] rd_data  = 16'h0000;
  int          rd_cnt   = 0;
  initial mem_ready = 1'b0;
  assign mem_rdata = rd_data;
  always @(posedge clk) begin
    #1;
    if (reset || mem_reset) rd_cnt = 0;
    else rd_cnt = rd_cnt + 1;
    mem_ready = (rd_delay != 0) && (rd_cnt == rd_delay);
  end

  // Reference model: who owns the reader, how long it has been out, what each port last got.
  bit          m_in_txn, m_recover, m_owner, m_last;
  int          m_elapsed;
  logic        e_a_ack, e_a_err, e_b_ack, e_b_err, e_busy, e_mem_reset;
  logic [15:0] e_a_rdata, e_b_rdata;
  logic [23:0] e_mem_addr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_txn = 0; m_recover = 0; m_owner = 0; m_last = 1; m_elapsed = 0;
      e_a_ack = 0; e_a_err = 0; e_b_ack = 0; e_b_err = 0;
      e_busy = 0; e_mem_reset = 1; e_mem_addr = 24'h0; e_a_rdata = 16'h0; e_b_rdata = 16'h0;
    end else begin
      e_a_ack = 0; e_a_err = 0; e_b_ack = 0; e_b_err = 0;
      if (m_recover) begin
        m_recover = 0;
      end else if (m_in_txn) begin
        m_elapsed = m_elapsed + 1;
        if (mem_ready || m_elapsed == TO) begin
          if (m_owner == 0) begin
            e_a_ack = 1; e_a_err = !mem_ready;
            if (mem_ready) e_a_rdata = mem_rdata;
          end else begin
            e_b_ack = 1; e_b_err = !mem_ready;
            if (mem_ready) e_b_rdata = mem_rdata;
          end
          m_last = m_owner; m_in_txn = 0; m_recover = 1;
          e_busy = 0; e_mem_reset = 1;
        end
      end else if (a_req || b_req) begin
        if (a_req && b_req) m_owner = !m_last;
        else m_owner = b_req;
        e_mem_addr = m_owner ? b_addr : a_addr;
        m_in_txn = 1; m_elapsed = 0; e_busy = 1; e_mem_reset = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_a_ack", a_ack, e_a_ack);
    chk("cmp_a_err", a_err, e_a_err);
    chk("cmp_b_ack", b_ack, e_b_ack);
    chk("cmp_b_err", b_err, e_b_err);
    chk("cmp_a_rdata", a_rdata, e_a_rdata);
    chk("cmp_b_rdata", b_rdata, e_b_rdata);
    chk("cmp_busy", busy, e_busy);
    chk("cmp_mem_reset", mem_reset, e_mem_reset);
    chk("cmp_mem_addr", mem_addr, e_mem_addr);
    chk("ack_exclusive", a_ack & b_ack, 1'b0);
  end

  // Wait for either ack; bcyc counts busy samples seen on the way.
  task automatic wait_ack(input int budget, output bit got, output bit port, output int bcyc);
    got = 0; port = 0; bcyc = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        got = 1; port = b_ack;
      end else if (busy) begin
        bcyc++;
      end
    end
    chk("ack_seen", got, 1'b1);
  endtask

  task automatic wait_busy(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("grant_seen", seen, 1'b1);
  endtask

  bit          got, port;
  int          bc, low;
  bit          exp_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [23:0] exp_addr [4] = '{24'h100002, 24'h180000, 24'h100002, 24'h180000};

  initial begin
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0; a_addr = 24'h0; b_addr = 24'h0;
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_mem_reset", mem_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", mem_addr, 24'h000000);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);
    reset = 1'b0;

    // Single A read, reader answers after 104 cycles.
    rd_delay = 104; rd_data = 16'hABCD; a_addr = 24'h100000; a_req = 1'b1;
    wait_ack(400, got, port, bc);
    chk("t1_port", port, 1'b0);
    chk("t1_err", a_err, 1'b0);
    chk("t1_rdata", a_rdata, 16'hABCD);
    chk("t1_addr", mem_addr, 24'h100000);
    chk("t1_busy_cycles", bc, 104);
    a_req = 1'b0;
    repeat (2) @(negedge clk);

    // Both ports held after reset: A, B, A, B with a two-cycle gap between grants.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_delay = 5; rd_data = 16'h1111; a_addr = 24'h100002; b_addr = 24'h180000;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(50, got, port, bc);
      chk("t2_port", port, exp_port[k]);
      chk("t2_addr", mem_addr, exp_addr[k]);
      if (k < 3) begin
        low = 1;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          if (busy) break;
          low++;
        end
        chk("t2_gap", low, 2);
      end else begin
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    // B timeout: reader never answers, b_rdata keeps the earlier 16'h1111.
    rd_delay = 0; b_addr = 24'h180004; b_req = 1'b1;
    wait_ack(400, got, port, bc);
    chk("t3_port", port, 1'b1);
    chk("t3_err", b_err, 1'b1);
    chk("t3_rdata", b_rdata, 16'h1111);
    chk("t3_cycles", bc, 255);
    b_req = 1'b0;
    @(negedge clk);
    chk("t3_mem_reset", mem_reset, 1'b1);
    repeat (2) @(negedge clk);

    // Ready lands on the timeout cycle: success wins.
    rd_delay = 255; rd_data = 16'h1234; a_addr = 24'h100008; a_req = 1'b1;
    wait_ack(400, got, port, bc);
    chk("t4_port", port, 1'b0);
    chk("t4_err", a_err, 1'b0);
    chk("t4_rdata", a_rdata, 16'h1234);
    chk("t4_cycles", bc, 255);
    a_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset 40 cycles into an A transaction; held a_req is re-granted afterwards.
    rd_delay = 0; a_addr = 24'h10000C; a_req = 1'b1;
    wait_busy(10);
    repeat (40) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_mem_reset", mem_reset, 1'b1);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_ack", a_ack, 1'b0);
    rd_delay = 8;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ack(50, got, port, bc);
    chk("t5_port", port, 1'b0);
    chk("t5_addr", mem_addr, 24'h10000C);
    chk("t5_cycles", bc, 8);
    chk("t5_rdata", a_rdata, 16'h1234);
    a_req = 1'b0;
    repeat (2) @(negedge clk);

    // A withdraws mid-transaction and still gets its ack; B follows right after recovery.
    rd_delay = 30; rd_data = 16'h5A5A; a_addr = 24'h100010; a_req = 1'b1;
    wait_busy(10);
    repeat (10) @(negedge clk);
    a_req = 1'b0; b_addr = 24'h180010; b_req = 1'b1;
    wait_ack(50, got, port, bc);
    chk("t6_a_port", port, 1'b0);
    chk("t6_a_err", a_err, 1'b0);
    chk("t6_a_rdata", a_rdata, 16'h5A5A);
    @(negedge clk);
    chk("t6_recover_busy", busy, 1'b0);
    @(negedge clk);
    chk("t6_b_grant", busy, 1'b1);
    chk("t6_b_addr", mem_addr, 24'h180010);
    wait_ack(50, got, port, bc);
    chk("t6_b_port", port, 1'b1);
    chk("t6_b_rdata", b_rdata, 16'h5A5A);
    b_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
